prog_cmd_ctrl: RTL and testbench

Byte-command controller for the SRAM programmer. It consumes bytes from the UART receive path and parses read, write and ping commands. It issues single 16-bit word requests to the external SRAM frontend and returns the read data or a status byte on the UART transmit path. It sits directly upstream of the SRAM frontend and drives its memory-request side.

---
 rtl/prog_cmd_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_prog_cmd_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_cmd_ctrl.sv
// Byte-command controller: parses UART read/write/ping commands, issues single
// 16-bit SRAM word requests and replies on UART tx. Optional 'N' opcode via PROG_AUTOINC_EN.
module prog_cmd_ctrl #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned TW = 16;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 16;

  localparam logic [7:0] OP_W  = 8'h57;
  localparam logic [7:0] OP_R  = 8'h52;
  localparam logic [7:0] OP_P  = 8'h50;
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_Q = 8'h3F;
  localparam logic [7:0] RSP_T = 8'h54;
`ifdef PROG_AUTOINC_EN
  localparam logic [7:0] OP_N  = 8'h4E;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_REQ, S_WAIT, S_TX0, S_TX1
  } state_t;

  state_t          state_q, state_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
`ifdef PROG_AUTOINC_EN
  logic [AW-1:0]   last_q, last_d;
`endif

  logic rx_fire, tx_fire, tmo_hit;

  // Outputs decode only registered state
  assign rx_ready  = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
  assign tx_valid  = (state_q == S_TX0) || (state_q == S_TX1);
  assign tx_data   = (state_q == S_TX0) ? rdata_q[15:8] : tx_byte_q;
  assign mem_valid = (state_q == S_REQ);
  assign mem_we    = we_q;
  assign mem_addr  = {addr_q[AW-1:1], 1'b0};
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);

  assign rx_fire = rx_valid && rx_ready;
  assign tx_fire = tx_valid && tx_ready;
  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      tx_byte_q <= '0;
`ifdef PROG_AUTOINC_EN
      last_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      tx_byte_q <= tx_byte_d;
`ifdef PROG_AUTOINC_EN
      last_q    <= last_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    tx_byte_d = tx_byte_q;
`ifdef PROG_AUTOINC_EN
    last_d    = last_q;
`endif
    case (state_q)
      S_IDLE: if (rx_fire) begin
        cnt_d = 2'd0;
        if (rx_data == OP_W) begin
          we_d    = 1'b1;
          state_d = S_ADDR;
        end else if (rx_data == OP_R) begin
          we_d    = 1'b0;
          state_d = S_ADDR;
        end else if (rx_data == OP_P) begin
          tx_byte_d = RSP_K;
          state_d   = S_TX1;
`ifdef PROG_AUTOINC_EN
        end else if (rx_data == OP_N) begin
          we_d    = 1'b1;
          addr_d  = last_q + AW'(2);
          state_d = S_DATA;
`endif
        end else begin
          tx_byte_d = RSP_Q;
          state_d   = S_TX1;
        end
      end
      S_ADDR: if (rx_fire) begin
        addr_d = {addr_q[AW-9:0], rx_data};
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          cnt_d   = 2'd0;
          state_d = we_q ? S_DATA : S_REQ;
        end
      end
      S_DATA: if (rx_fire) begin
        wdata_d = {wdata_q[7:0], rx_data};
        cnt_d   = cnt_q + 2'd1;
        if (cnt_q == 2'd1) begin
          cnt_d   = 2'd0;
          state_d = S_REQ;
        end
      end
      S_REQ: if (mem_ready) begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        // Completion takes priority over a coincident timeout
        if (mem_done) begin
`ifdef PROG_AUTOINC_EN
          last_d = {addr_q[AW-1:1], 1'b0};
`endif
          if (we_q) begin
            tx_byte_d = RSP_K;
            state_d   = S_TX1;
          end else begin
            rdata_d = mem_rdata;
            state_d = S_TX0;
          end
        end else if (tmo_hit) begin
          tx_byte_d = RSP_T;
          state_d   = S_TX1;
        end
      end
      S_TX0: if (tx_fire) begin
        tx_byte_d = rdata_q[7:0];
        state_d   = S_TX1;
      end
      S_TX1: if (tx_fire) begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_prog_cmd_ctrl.sv
// Directed self-checking bench for prog_cmd_ctrl (TIMEOUT=8); drives the UART
// and memory-frontend sides and checks responses against hand-computed values.
module tb_prog_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_done;
  logic [15:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;

  always #5 clk = ~clk;

  prog_cmd_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .busy(busy)
  );

  always @(posedge clk) if (mem_valid && mem_ready) acc_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("rx_accept_timeout", 32'(rx_ready), 32'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] exp);
    int n = 0;
    tx_ready = 1'b1;
    while (!tx_valid && n < 50) begin
      tick();
      n++;
    end
    check(tag, 32'(tx_data), 32'(exp));
    tick();
    tx_ready = 1'b0;
  endtask

  // Accept the pending request and pulse done in the first WAIT cycle
  task automatic mem_complete(input logic [15:0] rd);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_done  = 1'b1;
    mem_rdata = rd;
    tick();
    mem_done  = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"},  32'(rx_ready),  32'd1);
    check({tag, "_tx_valid"},  32'(tx_valid),  32'd0);
    check({tag, "_tx_data"},   32'(tx_data),   32'd0);
    check({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
    check({tag, "_mem_we"},    32'(mem_we),    32'd0);
    check({tag, "_mem_addr"},  mem_addr,       32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  initial begin
    int acc0;
    logic [7:0] wr_cmd [7] = '{8'h57, 8'h00, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD};
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    mem_ready = 1'b0; mem_done = 1'b0; mem_rdata = '0;
    tick(); tick();
    check_reset_vals("rst");
    rst = 1'b0;
    tick();

    // Write 0x1234 <- 0xABCD, done two cycles after acceptance
    acc0 = acc_cnt;
    foreach (wr_cmd[i]) send_byte(wr_cmd[i]);
    check("wr_mem_valid", 32'(mem_valid), 32'd1);
    check("wr_mem_we", 32'(mem_we), 32'd1);
    check("wr_mem_addr", mem_addr, 32'h0000_1234);
    check("wr_mem_wdata", 32'(mem_wdata), 32'hABCD);
    check("wr_busy", 32'(busy), 32'd1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("wr_valid_drop", 32'(mem_valid), 32'd0);
    tick();
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    check("wr_tx_valid", 32'(tx_valid), 32'd1);
    recv_byte("wr_resp", 8'h4B);
    check("wr_accepts", 32'(acc_cnt - acc0), 32'd1);

    // Read 0x10 with frontend stalling 5 cycles
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    for (int i = 0; i < 5; i++) begin
      check("rd_valid_held", 32'(mem_valid), 32'd1);
      check("rd_rx_ready_low", 32'(rx_ready), 32'd0);
      tick();
    end
    check("rd_mem_we", 32'(mem_we), 32'd0);
    check("rd_mem_addr", mem_addr, 32'h0000_0010);
    mem_complete(16'h5AA5);
    check("rd_rx_ready_tx0", 32'(rx_ready), 32'd0);
    recv_byte("rd_hi", 8'h5A);
    check("rd_lo_valid", 32'(tx_valid), 32'd1);
    check("rd_lo_data", 32'(tx_data), 32'hA5);
    recv_byte("rd_lo", 8'hA5);
    check("rd_idle", 32'(busy), 32'd0);

    // Ping, unknown opcode, 'N'
    acc0 = acc_cnt;
    send_byte(8'h50);
    recv_byte("ping", 8'h4B);
    send_byte(8'h00);
    recv_byte("unknown", 8'h3F);
    check("ping_no_mem", 32'(acc_cnt - acc0), 32'd0);
`ifndef PROG_AUTOINC_EN
    send_byte(8'h4E);
    recv_byte("n_unknown", 8'h3F);
`endif

    // Read timeout: no done, 'T' exactly 8 cycles after WAIT entry
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) check("tmo_not_yet", 32'(tx_valid), 32'd0);
    end
    check("tmo_tx_valid", 32'(tx_valid), 32'd1);
    mem_done = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_done = 1'b0;
    recv_byte("tmo_resp", 8'h54);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    check("late_done_idle", 32'(busy), 32'd0);
    send_byte(8'h50);
    recv_byte("post_tmo_ping", 8'h4B);

    // Reset mid-ADDR, then a clean read of 0x20
    send_byte(8'h52); send_byte(8'hAA); send_byte(8'hBB);
    rst = 1'b1;
    #2;
    check_reset_vals("midrst");
    tick();
    rst = 1'b0;
    tick();
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
    check("rst_rd_addr", mem_addr, 32'h0000_0020);
    check("rst_rd_we", 32'(mem_we), 32'd0);
    mem_complete(16'h1234);
    recv_byte("rst_rd_hi", 8'h12);
    recv_byte("rst_rd_lo", 8'h34);

`ifdef PROG_AUTOINC_EN
    // Auto-increment write wraps past 0xFFFFFFFE
    send_byte(8'h57); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFE);
    send_byte(8'h00); send_byte(8'h01);
    check("ai_w_addr", mem_addr, 32'hFFFF_FFFE);
    mem_complete(16'h0000);
    recv_byte("ai_w_resp", 8'h4B);
    send_byte(8'h4E); send_byte(8'h11); send_byte(8'h22);
    check("ai_n_valid", 32'(mem_valid), 32'd1);
    check("ai_n_we", 32'(mem_we), 32'd1);
    check("ai_n_addr", mem_addr, 32'h0000_0000);
    check("ai_n_wdata", 32'(mem_wdata), 32'h1122);
    mem_complete(16'h0000);
    recv_byte("ai_n_resp", 8'h4B);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
